// File: rtl/systolic_array_os.sv
// systolic_array_os: output-stationary ARR_SIZE x ARR_SIZE systolic matrix multiply (C = A x B),
// streamed operand beats, internal input skew, flush and row-serial result drain.
module systolic_array_os #(
    parameter int ARR_SIZE = 4,
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 32,
    parameter int K_W      = 16,
    localparam int RW      = ARR_SIZE > 1 ? $clog2(ARR_SIZE) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic [K_W-1:0]               i_k_len,
    input  logic                         i_signed,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  logic [DATA_W*ARR_SIZE-1:0]   i_a,
    input  logic [DATA_W*ARR_SIZE-1:0]   i_b,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [ACC_W*ARR_SIZE-1:0]    o_out_row,
    output logic [RW-1:0]                o_row_idx,
    output logic                         o_busy,
    output logic                         o_done
);
    localparam int FW = $clog2(2 * ARR_SIZE) + 1;
    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_t;
    state_t state, state_n;
    logic [K_W-1:0] k_len, beat_cnt;
    logic [FW-1:0] flush_cnt;
    logic [RW-1:0] row;
    logic sgn, fire, out_fire, clr, en, last_beat, flush_end, last_row;
    logic [ARR_SIZE*ARR_SIZE*DATA_W-1:0] a_tap, b_tap;
    logic [ARR_SIZE*ARR_SIZE*ACC_W-1:0] acc_all;

    always_comb begin
        fire      = state == STREAM && i_in_valid;
        out_fire  = state == DRAIN && i_out_ready;
        clr       = state == IDLE && i_start;
        en        = fire || state == FLUSH;
        last_beat = fire && beat_cnt == k_len - K_W'(1);
        flush_end = flush_cnt == FW'(2 * (ARR_SIZE - 1) - 1);
        last_row  = row == RW'(ARR_SIZE - 1);
        state_n   = state;
        case (state)
            IDLE:   state_n = i_start ? (i_k_len != '0 ? STREAM : DRAIN) : IDLE;
            STREAM: state_n = last_beat ? (ARR_SIZE > 1 ? FLUSH : DRAIN) : STREAM;
            FLUSH:  state_n = flush_end ? DRAIN : FLUSH;
            DRAIN:  state_n = out_fire && last_row ? IDLE : DRAIN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k_len     <= '0;
            sgn       <= 1'b0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            row       <= '0;
            o_done    <= 1'b0;
        end else begin
            state     <= state_n;
            k_len     <= clr ? i_k_len : k_len;
            sgn       <= clr ? i_signed : sgn;
            beat_cnt  <= clr ? '0 : fire ? beat_cnt + K_W'(1) : beat_cnt;
            flush_cnt <= state == FLUSH ? flush_cnt + FW'(1) : '0;
            row       <= clr ? '0 : out_fire ? (last_row ? '0 : row + RW'(1)) : row;
            o_done    <= out_fire && last_row;
        end
    end

    assign o_in_ready  = state == STREAM;
    assign o_out_valid = state == DRAIN;
    assign o_busy      = state != IDLE;
    assign o_row_idx   = row;
    assign o_out_row   = acc_all[int'(row)*ARR_SIZE*ACC_W +: ARR_SIZE*ACC_W];

    // One shift chain per A row / B column covers both the skew and the PE-to-PE hops:
    // the tap at delay i+j feeds PE(i,j).
    for (genvar i = 0; i < ARR_SIZE; i++) begin : g_a
        localparam int L  = i + ARR_SIZE - 1;
        localparam int QW = (L > 0 ? L : 1) * DATA_W;
        logic [DATA_W-1:0] d;
        logic [QW-1:0] q;
        assign d = fire ? i_a[i*DATA_W +: DATA_W] : '0;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) q <= '0;
            else if (clr) q <= '0;
            else if (en) q <= QW'({q, d});
        end
        for (genvar j = 0; j < ARR_SIZE; j++) begin : g_t
            if (i + j == 0) begin : g_d
                assign a_tap[(i*ARR_SIZE+j)*DATA_W +: DATA_W] = d;
            end else begin : g_q
                assign a_tap[(i*ARR_SIZE+j)*DATA_W +: DATA_W] = q[(i+j-1)*DATA_W +: DATA_W];
            end
        end
    end

    for (genvar i = 0; i < ARR_SIZE; i++) begin : g_b
        localparam int L  = i + ARR_SIZE - 1;
        localparam int QW = (L > 0 ? L : 1) * DATA_W;
        logic [DATA_W-1:0] d;
        logic [QW-1:0] q;
        assign d = fire ? i_b[i*DATA_W +: DATA_W] : '0;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) q <= '0;
            else if (clr) q <= '0;
            else if (en) q <= QW'({q, d});
        end
        for (genvar j = 0; j < ARR_SIZE; j++) begin : g_t
            if (i + j == 0) begin : g_d
                assign b_tap[(i*ARR_SIZE+j)*DATA_W +: DATA_W] = d;
            end else begin : g_q
                assign b_tap[(i*ARR_SIZE+j)*DATA_W +: DATA_W] = q[(i+j-1)*DATA_W +: DATA_W];
            end
        end
    end

    for (genvar i = 0; i < ARR_SIZE; i++) begin : g_r
        for (genvar j = 0; j < ARR_SIZE; j++) begin : g_c
            logic [DATA_W-1:0] a, b;
            logic [2*DATA_W-1:0] pu;
            logic signed [2*DATA_W-1:0] ps;
            logic [ACC_W-1:0] ext, acc;
            assign a   = a_tap[(i*ARR_SIZE+j)*DATA_W +: DATA_W];
            assign b   = b_tap[(j*ARR_SIZE+i)*DATA_W +: DATA_W];
            assign pu  = (2*DATA_W)'(a) * (2*DATA_W)'(b);
            assign ps  = (2*DATA_W)'($signed(a)) * (2*DATA_W)'($signed(b));
            assign ext = sgn ? ACC_W'(ps) : ACC_W'(pu);
            always_ff @(posedge clk or posedge rst) begin
                if (rst) acc <= '0;
                else if (clr) acc <= '0;
                else if (en) acc <= acc + ext;
            end
            assign acc_all[(i*ARR_SIZE+j)*ACC_W +: ACC_W] = acc;
        end
    end
endmodule

// File: tb/tb_systolic_array_os.sv
// tb_systolic_array_os: scoreboard bench for systolic_array_os; expected rows come from a
// plain matrix-product model and are popped by a monitor on every result handshake.
module tb_systolic_array_os;
    localparam int N = 4, DW = 16, AW = 32, KW = 16, KMAX = 8;
    logic clk = 0, rst = 1;
    logic i_start = 0, i_signed = 0, i_in_valid = 0, i_out_ready = 1;
    logic [KW-1:0] i_k_len = '0;
    logic [DW*N-1:0] i_a = '0, i_b = '0;
    logic o_in_ready, o_out_valid, o_busy, o_done;
    logic [AW*N-1:0] o_out_row;
    logic [1:0] o_row_idx;

    systolic_array_os #(.ARR_SIZE(N), .DATA_W(DW), .ACC_W(AW), .K_W(KW)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_k_len(i_k_len), .i_signed(i_signed),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_a(i_a), .i_b(i_b),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_row(o_out_row),
        .o_row_idx(o_row_idx), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, done_cnt = 0;
    logic [DW-1:0] am [N][KMAX];
    logic [DW-1:0] bm [KMAX][N];
    logic [N*AW-1:0] exp_row_q[$];
    int exp_idx_q[$];
    bit manual_rdy = 0;
    int rdy_pct = 100;

    function automatic void check(string name, logic [N*AW-1:0] act, logic [N*AW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    function automatic void push_expect(int k, bit sg);
        for (int r = 0; r < N; r++) begin
            logic [N*AW-1:0] rv = '0;
            for (int c = 0; c < N; c++) begin
                longint s = 0;
                for (int t = 0; t < k; t++)
                    s += sg ? longint'($signed(am[r][t])) * longint'($signed(bm[t][c]))
                            : longint'(am[r][t]) * longint'(bm[t][c]);
                rv[c*AW +: AW] = s[31:0];
            end
            exp_row_q.push_back(rv);
            exp_idx_q.push_back(r);
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk); #1;
            if (!manual_rdy) i_out_ready = $urandom_range(99) < rdy_pct;
        end
    end

    initial begin
        bit stall_prev = 0;
        logic [N*AW-1:0] prev_row;
        logic [1:0] prev_idx;
        forever begin
            @(negedge clk);
            if (rst) stall_prev = 0;
            else begin
                if (o_done) done_cnt++;
                if (stall_prev && o_out_valid) begin
                    check("stall_row", o_out_row, prev_row);
                    check("stall_idx", o_row_idx, prev_idx);
                end
                stall_prev = o_out_valid && !i_out_ready;
                prev_row = o_out_row;
                prev_idx = o_row_idx;
                if (o_out_valid && i_out_ready) begin
                    if (exp_row_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_row idx=%0d required=none", o_row_idx);
                    end else begin
                        check("row", o_out_row, exp_row_q.pop_front());
                        check("row_idx", o_row_idx, exp_idx_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        while (o_busy && n < 2000) begin tick(); n++; end
        if (o_busy) begin total++; bad++; $display("FAIL %s timeout busy=1 required=0", name); end
    endtask

    task automatic issue(int k, bit sg, int vmode, int nbeats, bit push);
        int beat = 0, c = 0;
        bit v, acc;
        if (push) push_expect(k, sg);
        i_start = 1; i_k_len = KW'(k); i_signed = sg;
        tick();
        i_start = 0;
        while (beat < nbeats && c < 1000) begin
            v = vmode == 0 ? 1'b1 : vmode == 1 ? (c % 3 == 0) : 1'($urandom_range(1));
            i_in_valid = v;
            for (int i = 0; i < N; i++) begin
                i_a[i*DW +: DW] = am[i][beat];
                i_b[i*DW +: DW] = bm[beat][i];
            end
            acc = v && o_in_ready;
            tick(); c++;
            if (acc) beat++;
        end
        i_in_valid = 0;
    endtask

    task automatic finish_job(string name, int d0);
        wait_idle(name);
        tick(); tick();
        check({name, "_done"}, done_cnt - d0, 1);
        check({name, "_drained"}, exp_row_q.size(), 0);
    endtask

    task automatic load_identity();
        for (int i = 0; i < N; i++)
            for (int t = 0; t < KMAX; t++) am[i][t] = DW'(i == t);
        for (int t = 0; t < KMAX; t++)
            for (int j = 0; j < N; j++) bm[t][j] = DW'(4 * t + j + 1);
    endtask

    task automatic fill(logic [DW-1:0] v);
        for (int i = 0; i < N; i++)
            for (int t = 0; t < KMAX; t++) begin am[i][t] = v; bm[t][i] = v; end
    endtask

    initial begin
        int d0, n;
        tick(); tick();
        check("reset_ctrl", {o_busy, o_in_ready, o_out_valid, o_done, o_row_idx}, 0);
        check("reset_row", o_out_row, 0);
        rst = 0;
        tick();

        load_identity();
        d0 = done_cnt;
        issue(4, 0, 0, 4, 1);
        check("ready_drop", o_in_ready, 0);
        n = 1;
        while (!o_out_valid && n < 50) begin tick(); n++; end
        check("latency", n, 2 * (N - 1) + 1);
        finish_job("identity", d0);

        fill(16'hFFFF);
        d0 = done_cnt; issue(3, 1, 0, 3, 1); finish_job("ffff_signed", d0);
        d0 = done_cnt; issue(3, 0, 0, 3, 1); finish_job("ffff_unsigned", d0);

        load_identity();
        d0 = done_cnt;
        issue(4, 0, 1, 4, 1);
        check("ready_drop_gappy", o_in_ready, 0);
        finish_job("gappy", d0);

        d0 = done_cnt;
        manual_rdy = 1; i_out_ready = 0;
        issue(4, 0, 0, 4, 1);
        n = 0;
        while (!o_out_valid && n < 50) begin tick(); n++; end
        i_out_ready = 1; tick();
        i_out_ready = 0;
        for (int s = 0; s < 5; s++) begin
            i_start = s == 2;
            tick();
        end
        i_start = 0;
        check("stall_hold", {o_out_valid, o_row_idx}, {1'b1, 2'd1});
        i_out_ready = 1; tick();
        check("stall_release", o_row_idx, 2);
        manual_rdy = 0;
        finish_job("stall", d0);
        check("start_ignored", o_busy, 0);

        d0 = done_cnt; issue(0, 0, 0, 0, 1); finish_job("k0_a", d0);
        d0 = done_cnt; issue(0, 1, 0, 0, 1); finish_job("k0_b", d0);
        d0 = done_cnt; issue(4, 0, 0, 4, 1); finish_job("after_k0", d0);

        issue(4, 0, 0, 2, 0);
        #2 rst = 1;
        #1 check("async_rst_ctrl", {o_busy, o_in_ready, o_out_valid, o_done, o_row_idx}, 0);
        check("async_rst_row", o_out_row, 0);
        tick(); tick();
        rst = 0;
        tick();
        d0 = done_cnt; issue(4, 0, 0, 4, 1); finish_job("post_rst", d0);

        rdy_pct = 60;
        for (int r = 0; r < 20; r++) begin
            int k = $urandom_range(KMAX);
            bit sg = 1'($urandom_range(1));
            for (int i = 0; i < N; i++)
                for (int t = 0; t < KMAX; t++) begin
                    am[i][t] = DW'($urandom);
                    bm[t][i] = DW'($urandom);
                end
            d0 = done_cnt;
            issue(k, sg, 2, k, 1);
            finish_job("random", d0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule

// File: doc/systolic_array_os.md
Name: systolic_array_os

Overview:
- Parametrised output-stationary ARR_SIZE x ARR_SIZE systolic matrix-multiply engine; computes C = A x B over a runtime-programmable inner dimension K.
- Successor to the fixed-width PE-grid MAC: adds internal input-skew registers, a valid/ready streaming input, a sequencing FSM (stream/flush/drain), signed/unsigned mode and row-serial result drain.
- Sits between the operand buffers and the result writeback path.

Parameters:
ARR_SIZE, 4, rows = columns of the PE grid (>=1)
DATA_W, 16, operand width
ACC_W, 32, accumulator/result width (>= 2*DATA_W)
K_W, 16, width of the K-length field

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
i_start  in  1  begin job (sampled only in IDLE)
i_k_len  in  K_W  inner dimension K, sampled with i_start
i_signed  in  1  1 = signed operands/products, sampled with i_start
i_in_valid  in  1  operand beat valid
o_in_ready  out  1  operand beat accepted when valid&ready
i_a  in  DATA_W*ARR_SIZE  column k of A; slice i -> row i
i_b  in  DATA_W*ARR_SIZE  row k of B; slice j -> column j
o_out_valid  out  1  result row valid
i_out_ready  in  1  result row consumed when valid&ready
o_out_row  out  ACC_W*ARR_SIZE  row r of C; slice j = C[r][j]
o_row_idx  out  max(1,$clog2(ARR_SIZE))  index r of o_out_row
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse after last row handshake

Behaviour:
- Reset (async, any state): FSM -> IDLE, all skew/PE registers and accumulators 0, all outputs 0.
- States: IDLE, STREAM, FLUSH, DRAIN.
- IDLE: i_start=1 -> clear all accumulators, latch K and mode; K!=0 -> STREAM, K==0 -> DRAIN (all-zero result).
- STREAM: o_in_ready=1. Array (skew regs, PE forwarding regs, accumulators) advances only on an accepted beat; no beat -> full freeze. After the K-th accepted beat -> FLUSH (ARR_SIZE>1) or DRAIN (ARR_SIZE==1).
- FLUSH: o_in_ready=0; zeros injected, array advances every cycle for exactly 2*(ARR_SIZE-1) cycles, then -> DRAIN.
- Timing: A slice i delayed i enabled cycles, B slice j delayed j; each PE hop adds 1 register. Beat k meets at PE(i,j) on the (k+i+j)-th enabled edge after acceptance; all products land before DRAIN.
- PE: acc <= acc + a*b; product 2*DATA_W, sign/zero-extended to ACC_W by latched mode; wraps modulo 2^ACC_W, no saturation.
- DRAIN: o_out_valid=1, o_row_idx=r starting at 0, o_out_row = accumulator row r (stable while stalled). Handshake -> r+1. Handshake at r=ARR_SIZE-1 -> IDLE, o_done=1 next cycle, accumulators retain values until next start.
- i_start outside IDLE ignored; i_in_valid outside STREAM ignored; o_out_valid 0 outside DRAIN.
- Total latency from last accepted beat to first o_out_valid: 2*(ARR_SIZE-1)+1 cycles.

Test Plan:
- ARR_SIZE=4, K=4, A=identity, B[k][j]=4k+j+1, unsigned, i_out_ready=1 -> rows 0..3 = {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}; first o_out_valid 7 cycles after 4th beat; o_done pulses once.
- K=3, all A=B=0xFFFF, signed -> every C[i][j]=3; unsigned repeat -> every C[i][j]=3*0xFFFE0001 mod 2^32 = 0xFFFA0003.
- K=4 identity job with i_in_valid toggling 1,0,0,1,... -> results identical to gapless run; o_in_ready drops after 4th accepted beat.
- DRAIN with i_out_ready held 0 for 5 cycles at r=1 -> o_out_row/o_row_idx=1 held stable, r=2 after release; i_start pulsed mid-drain ignored.
- K=0 start -> immediate DRAIN, four all-zero rows, o_done; second job after first shows no carry-over.
- rst asserted mid-STREAM (2 of 4 beats) -> all outputs 0 asynchronously; fresh identity job after release gives exact expected rows.
